// File: rtl/opb_register_ppc2simulink_pkg.sv
// Shared types and constants for the PPC-to-fabric OPB control register.
package opb_ppc2sl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  localparam logic [5:0] OFF_DATA    = 6'h00;
  localparam logic [5:0] OFF_WRCOUNT = 6'h01;

  localparam int LANES     = 4;
  localparam int LANE_BITS = 8;

  // OPB lane 0 carries the most significant byte of the little-endian word.
  function automatic int lane_msb(input int lane);
    return 31 - LANE_BITS * lane;
  endfunction

endpackage

// File: rtl/opb_register_ppc2simulink_if.sv
// OPB slave-side signal bundle; big-endian bit numbering as on the bus.
interface opb_register_ppc2simulink_if;

  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;

  logic [0:31] Sl_DBus;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;
  logic        Sl_xferAck;

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
  );

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
  );

endinterface

// File: rtl/opb_register_ppc2simulink_be_merge.sv
// Byte-enable merge of bus write data into the stored word, undoing the
// OPB [0:31] bit numbering so bus bit 0 lands on data bit 31.
module opb_be_merge
  import opb_ppc2sl_pkg::*;
(
  input  logic [31:0] old_data,
  input  logic [0:31] bus_data,
  input  logic [0:3]  be,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_data;
    for (int lane = 0; lane < LANES; lane++) begin
      if (be[lane]) begin
        for (int b = 0; b < LANE_BITS; b++) begin
          merged[lane_msb(lane) - b] = bus_data[LANE_BITS * lane + b];
        end
      end
    end
  end

endmodule

// File: rtl/opb_register_ppc2simulink.sv
// OPB slave holding a byte-maskable control word for fabric logic plus a
// read-only count of effective writes; every beat is acked one cycle later.
module opb_register_ppc2simulink
  import opb_ppc2sl_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR    = 32'h01008200,
  parameter logic [31:0] C_HIGHADDR    = 32'h010082FF,
  parameter int          C_OPB_AWIDTH  = 32,
  parameter int          C_OPB_DWIDTH  = 32,
  parameter              C_FAMILY      = "virtex6",
  parameter logic [31:0] C_RESET_VALUE = 32'h00000000
) (
  input  logic                              OPB_Clk,
  input  logic                              OPB_Rst_n,
  opb_register_ppc2simulink_if.slave        opb,
  output logic [31:0]                       user_data_out,
  output logic                              user_data_valid
);

  state_t      state;
  state_t      state_next;
  logic        hit;
  logic        accept;
  logic [5:0]  word_idx;
  logic [5:0]  off_q;
  logic        rnw_q;
  logic [31:0] rd_word;
  logic [31:0] rd_reg;
  logic [31:0] data;
  logic [31:0] data_merged;
  logic [31:0] wrcount;
  logic        write_fire;
  logic        be_any;
  logic        valid_q;
  logic        unused_ok;

  assign hit      = opb.OPB_select
                 && (opb.OPB_ABus >= C_BASEADDR)
                 && (opb.OPB_ABus <= C_HIGHADDR);
  assign word_idx = opb.OPB_ABus[24:29];
  assign accept   = (state == IDLE) && hit;

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A beat always takes exactly one ACK cycle, so a master holding select
  // starts a fresh beat in the following IDLE cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (hit) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rd_word = '0;
    case (word_idx)
      OFF_DATA:    rd_word = data;
      OFF_WRCOUNT: rd_word = wrcount;
      default:     rd_word = '0;
    endcase
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      off_q  <= '0;
      rnw_q  <= 1'b1;
      rd_reg <= '0;
    end else begin
      rd_reg <= '0;
      if (accept) begin
        off_q <= word_idx;
        rnw_q <= opb.OPB_RNW;
        if (opb.OPB_RNW) begin
          rd_reg <= rd_word;
        end
      end
    end
  end

  opb_be_merge u_be_merge (
    .old_data (data),
    .bus_data (opb.OPB_DBus),
    .be       (opb.OPB_BE),
    .merged   (data_merged)
  );

  // Write data and byte enables are taken at the end of the ACK cycle; a
  // master that dropped select meanwhile still gets its ack but no write.
  assign write_fire = (state == ACK) && opb.OPB_select && !rnw_q
                   && (off_q == OFF_DATA);
  assign be_any     = |opb.OPB_BE;

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      data    <= C_RESET_VALUE;
      wrcount <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= write_fire && be_any;
      if (write_fire) begin
        data <= data_merged;
      end
      if (write_fire && be_any) begin
        wrcount <= wrcount + 32'd1;
      end
    end
  end

  assign opb.Sl_DBus    = rd_reg;
  assign opb.Sl_xferAck = (state == ACK);
  assign opb.Sl_errAck  = 1'b0;
  assign opb.Sl_retry   = 1'b0;
  assign opb.Sl_toutSup = 1'b0;

  assign user_data_out   = data;
  assign user_data_valid = valid_q;

  assign unused_ok = ^{opb.OPB_seqAddr, opb.OPB_ABus[30:31],
                       (C_OPB_AWIDTH != 32), (C_OPB_DWIDTH != 32),
                       (C_FAMILY != "")};

endmodule

// File: tb/tb_opb_register_ppc2simulink.sv
// Self-checking bench: directed vector table, hand-written corner sequences
// and random beats checked against a word-level register model.
module tb_opb_register_ppc2simulink;

  localparam logic [31:0] BASE = 32'h01008200;
  localparam logic [31:0] HIGH = 32'h010082FF;

  typedef struct {
    logic [31:0] addr;
    logic        rnw;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        exp_ack;
    logic [31:0] exp_rd;
    logic        exp_pulse;
    logic [31:0] exp_user;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] user_data_out;
  logic        user_data_valid;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_data;
  logic [31:0] m_count;

  vec_t vecs[15];

  opb_register_ppc2simulink_if bus ();

  opb_register_ppc2simulink dut (
    .OPB_Clk         (clk),
    .OPB_Rst_n       (rst_n),
    .opb             (bus.slave),
    .user_data_out   (user_data_out),
    .user_data_valid (user_data_valid)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] mask = '0;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mask = mask | (32'hFF << (8 * i));
    end
    return mask;
  endfunction

  // Register-level model: window decode by arithmetic, byte-masked update.
  task automatic model_beat(input logic [31:0] addr, input logic rnw,
                            input logic [3:0] be, input logic [31:0] wdata,
                            input logic abort,
                            output logic exp_ack, output logic [31:0] exp_rd,
                            output logic exp_pulse, output logic [31:0] exp_user);
    logic        in_win;
    logic [31:0] off;
    in_win    = (addr >= BASE) && (addr <= HIGH);
    off       = (addr - BASE) / 4;
    exp_ack   = in_win;
    exp_rd    = '0;
    exp_pulse = 1'b0;
    if (in_win && rnw) begin
      if (off == 0)      exp_rd = m_data;
      else if (off == 1) exp_rd = m_count;
    end
    if (in_win && !rnw && !abort && off == 0 && be != 4'b0000) begin
      m_data    = (m_data & ~lane_mask(be)) | (wdata & lane_mask(be));
      m_count   = m_count + 1;
      exp_pulse = 1'b1;
    end
    exp_user = m_data;
  endtask

  // One beat starting mid-cycle N with select raised; leaves select low.
  task automatic apply_stimulus(input string tag, input logic [31:0] addr,
                                input logic rnw, input logic [3:0] be,
                                input logic [31:0] wdata, input logic abort,
                                input logic exp_ack, input logic [31:0] exp_rd,
                                input logic exp_pulse, input logic [31:0] exp_user);
    bus.OPB_ABus   = addr;
    bus.OPB_RNW    = rnw;
    bus.OPB_BE     = be;
    bus.OPB_DBus   = wdata;
    bus.OPB_select = 1'b1;
    @(negedge clk);
    check_output({tag, "/ack_n1"}, {31'd0, bus.Sl_xferAck}, {31'd0, exp_ack});
    check_output({tag, "/rdata_n1"}, bus.Sl_DBus, exp_rd);
    check_output({tag, "/valid_n1"}, {31'd0, user_data_valid}, 32'd0);
    if (abort) bus.OPB_select = 1'b0;
    @(negedge clk);
    bus.OPB_select = 1'b0;
    check_output({tag, "/ack_n2"}, {31'd0, bus.Sl_xferAck}, 32'd0);
    check_output({tag, "/rdata_n2"}, bus.Sl_DBus, 32'd0);
    check_output({tag, "/valid_n2"}, {31'd0, user_data_valid}, {31'd0, exp_pulse});
    check_output({tag, "/user_n2"}, user_data_out, exp_user);
    @(negedge clk);
    check_output({tag, "/valid_n3"}, {31'd0, user_data_valid}, 32'd0);
  endtask

  task automatic model_and_apply(input string tag, input logic [31:0] addr,
                                 input logic rnw, input logic [3:0] be,
                                 input logic [31:0] wdata, input logic abort);
    logic        e_ack;
    logic [31:0] e_rd;
    logic        e_pulse;
    logic [31:0] e_user;
    model_beat(addr, rnw, be, wdata, abort, e_ack, e_rd, e_pulse, e_user);
    apply_stimulus(tag, addr, rnw, be, wdata, abort, e_ack, e_rd, e_pulse, e_user);
  endtask

  initial begin
    logic [31:0] wa;
    logic [31:0] wb;
    logic [31:0] addr;
    int          pick;

    bus.OPB_ABus    = '0;
    bus.OPB_BE      = '0;
    bus.OPB_DBus    = '0;
    bus.OPB_RNW     = 1'b1;
    bus.OPB_select  = 1'b0;
    bus.OPB_seqAddr = 1'b0;

    vecs[0]  = '{32'h01008204, 1'b1, 4'h0, 32'h0,        1'b1, 32'h0,        1'b0, 32'h0};
    vecs[1]  = '{32'h01008200, 1'b0, 4'hF, 32'hDEADBEEF, 1'b1, 32'h0,        1'b1, 32'hDEADBEEF};
    vecs[2]  = '{32'h01008204, 1'b1, 4'h0, 32'h0,        1'b1, 32'h1,        1'b0, 32'hDEADBEEF};
    vecs[3]  = '{32'h01008200, 1'b0, 4'h5, 32'h11223344, 1'b1, 32'h0,        1'b1, 32'hDE22BE44};
    vecs[4]  = '{32'h01008200, 1'b0, 4'h0, 32'hFFFFFFFF, 1'b1, 32'h0,        1'b0, 32'hDE22BE44};
    vecs[5]  = '{32'h01008204, 1'b1, 4'h0, 32'h0,        1'b1, 32'h2,        1'b0, 32'hDE22BE44};
    vecs[6]  = '{32'h01008200, 1'b1, 4'h0, 32'h0,        1'b1, 32'hDE22BE44, 1'b0, 32'hDE22BE44};
    vecs[7]  = '{32'h01008210, 1'b1, 4'h0, 32'h0,        1'b1, 32'h0,        1'b0, 32'hDE22BE44};
    vecs[8]  = '{32'h01008210, 1'b0, 4'hF, 32'hCAFEF00D, 1'b1, 32'h0,        1'b0, 32'hDE22BE44};
    vecs[9]  = '{32'h01008204, 1'b0, 4'hF, 32'h12345678, 1'b1, 32'h0,        1'b0, 32'hDE22BE44};
    vecs[10] = '{32'h01008204, 1'b1, 4'h0, 32'h0,        1'b1, 32'h2,        1'b0, 32'hDE22BE44};
    vecs[11] = '{32'h01008300, 1'b1, 4'h0, 32'h0,        1'b0, 32'h0,        1'b0, 32'hDE22BE44};
    vecs[12] = '{32'h01008300, 1'b0, 4'hF, 32'hA5A5A5A5, 1'b0, 32'h0,        1'b0, 32'hDE22BE44};
    vecs[13] = '{32'h010081FC, 1'b1, 4'h0, 32'h0,        1'b0, 32'h0,        1'b0, 32'hDE22BE44};
    vecs[14] = '{32'h010082FC, 1'b1, 4'h0, 32'h0,        1'b1, 32'h0,        1'b0, 32'hDE22BE44};

    repeat (3) @(negedge clk);
    check_output("rst/ack", {31'd0, bus.Sl_xferAck}, 32'd0);
    check_output("rst/rdata", bus.Sl_DBus, 32'd0);
    check_output("rst/user", user_data_out, 32'd0);
    check_output("rst/valid", {31'd0, user_data_valid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      apply_stimulus($sformatf("vec%0d", i), vecs[i].addr, vecs[i].rnw, vecs[i].be,
                     vecs[i].wdata, 1'b0, vecs[i].exp_ack, vecs[i].exp_rd,
                     vecs[i].exp_pulse, vecs[i].exp_user);
    end
    m_data  = 32'hDE22BE44;
    m_count = 32'd2;

    // Select held across two beats: two acks, two pulses, two counts.
    wa = $urandom;
    wb = $urandom;
    bus.OPB_ABus = BASE; bus.OPB_RNW = 1'b0; bus.OPB_BE = 4'hF;
    bus.OPB_DBus = wa;   bus.OPB_select = 1'b1;
    @(negedge clk);
    check_output("b2b/ack1", {31'd0, bus.Sl_xferAck}, 32'd1);
    @(negedge clk);
    bus.OPB_DBus = wb;
    check_output("b2b/gap_ack", {31'd0, bus.Sl_xferAck}, 32'd0);
    check_output("b2b/valid1", {31'd0, user_data_valid}, 32'd1);
    check_output("b2b/user1", user_data_out, wa);
    @(negedge clk);
    check_output("b2b/ack2", {31'd0, bus.Sl_xferAck}, 32'd1);
    check_output("b2b/valid_gap", {31'd0, user_data_valid}, 32'd0);
    @(negedge clk);
    bus.OPB_select = 1'b0;
    check_output("b2b/valid2", {31'd0, user_data_valid}, 32'd1);
    check_output("b2b/user2", user_data_out, wb);
    @(negedge clk);
    m_data  = wb;
    m_count = m_count + 2;
    model_and_apply("b2b/count", BASE + 4, 1'b1, 4'h0, 32'h0, 1'b0);

    model_and_apply("abort", BASE, 1'b0, 4'hF, 32'h0BADF00D, 1'b1);

    force dut.wrcount = 32'hFFFFFFFF;
    @(negedge clk);
    release dut.wrcount;
    m_count = 32'hFFFFFFFF;
    model_and_apply("wrap/write", BASE, 1'b0, 4'h8, $urandom, 1'b0);
    model_and_apply("wrap/read", BASE + 4, 1'b1, 4'h0, 32'h0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      pick = $urandom_range(0, 9);
      if (pick < 4)      addr = BASE;
      else if (pick < 6) addr = BASE + 4;
      else if (pick < 8) addr = BASE + ($urandom_range(0, 63) << 2);
      else if (pick == 8) addr = 32'h01008300 + ($urandom_range(0, 255) << 2);
      else               addr = 32'h010081FC - ($urandom_range(0, 63) << 2);
      model_and_apply($sformatf("rand%0d", i), addr, ($urandom_range(0, 2) == 0),
                      4'($urandom_range(0, 15)), $urandom,
                      ($urandom_range(0, 7) == 0));
    end
    model_and_apply("rand/data", BASE, 1'b1, 4'h0, 32'h0, 1'b0);
    model_and_apply("rand/count", BASE + 4, 1'b1, 4'h0, 32'h0, 1'b0);

    // Reset asserted during the ACK cycle of a write aborts it outright.
    bus.OPB_ABus = BASE; bus.OPB_RNW = 1'b0; bus.OPB_BE = 4'hF;
    bus.OPB_DBus = 32'h55AA55AA; bus.OPB_select = 1'b1;
    @(negedge clk);
    check_output("rstack/ack", {31'd0, bus.Sl_xferAck}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_output("rstack/ack_drop", {31'd0, bus.Sl_xferAck}, 32'd0);
    check_output("rstack/user", user_data_out, 32'd0);
    bus.OPB_select = 1'b0;
    @(negedge clk);
    check_output("rstack/valid", {31'd0, user_data_valid}, 32'd0);
    check_output("rstack/user_hold", user_data_out, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("rstack/valid_after", {31'd0, user_data_valid}, 32'd0);
    m_data  = 32'h0;
    m_count = 32'h0;
    model_and_apply("rstack/data", BASE, 1'b1, 4'h0, 32'h0, 1'b0);
    model_and_apply("rstack/count", BASE + 4, 1'b1, 4'h0, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
